// File: rtl/exu_pkg.sv
// Shared definitions for the execute stage: data width, op codes and occupancy states.
package exu_pkg;

  localparam int unsigned XLEN = 64;

  // Code 15 is intentionally left unnamed; it produces a zero result.
  typedef enum logic [3:0] {
    OP_SRAW = 4'd0,
    OP_SRLW = 4'd1,
    OP_SLLW = 4'd2,
    OP_SRL  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRA  = 4'd5,
    OP_ADD  = 4'd6,
    OP_SUB  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_SLT  = 4'd11,
    OP_SLTU = 4'd12,
    OP_ADDW = 4'd13,
    OP_SUBW = 4'd14
  } exu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } exu_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] w);
    return {{(XLEN-32){w[31]}}, w};
  endfunction

endpackage

// File: rtl/exu_shifter.sv
// Combinational shifter for ops 0-5; W-ops shift the low word and sign-extend.
module exu_shifter
  import exu_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [5:0]      i_shamt,
  output logic [XLEN-1:0] o_result
);

  logic [31:0] w_word;

  always_comb begin
    w_word   = '0;
    o_result = '0;
    case (exu_op_e'(i_op))
      OP_SRAW: begin
        w_word   = $signed(i_src1[31:0]) >>> i_shamt[4:0];
        o_result = sext32(w_word);
      end
      OP_SRLW: begin
        w_word   = i_src1[31:0] >> i_shamt[4:0];
        o_result = sext32(w_word);
      end
      OP_SLLW: begin
        w_word   = i_src1[31:0] << i_shamt[4:0];
        o_result = sext32(w_word);
      end
      OP_SRL:  o_result = i_src1 >> i_shamt;
      OP_SLL:  o_result = i_src1 << i_shamt;
      OP_SRA:  o_result = $signed(i_src1) >>> i_shamt;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/exu_stage.sv
// Execute stage with valid/ready handshakes on both sides and a registered result.
// EXU_SKID_EN selects a 2-entry skid buffer; otherwise a single entry with combinational in_ready.
module exu_stage
  import exu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen
);

  exu_state_e      r_state;
  logic [XLEN-1:0] r_out_result;
  logic [4:0]      r_out_rd;
  logic            r_out_wen;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_result;
  logic [31:0]     w_word;
  logic            w_accept;
  logic            w_retire;
`ifdef EXU_SKID_EN
  logic [XLEN-1:0] r_skid_result;
  logic [4:0]      r_skid_rd;
  logic            r_skid_wen;
  logic            r_in_ready;
`endif

  exu_shifter u_shifter (
    .i_op     (in_op),
    .i_src1   (in_src1),
    .i_shamt  (in_src2[5:0]),
    .o_result (w_shift)
  );

  always_comb begin
    w_word   = '0;
    w_result = '0;
    case (exu_op_e'(in_op))
      OP_SRAW, OP_SRLW, OP_SLLW,
      OP_SRL, OP_SLL, OP_SRA: w_result = w_shift;
      OP_ADD:  w_result = in_src1 + in_src2;
      OP_SUB:  w_result = in_src1 - in_src2;
      OP_AND:  w_result = in_src1 & in_src2;
      OP_OR:   w_result = in_src1 | in_src2;
      OP_XOR:  w_result = in_src1 ^ in_src2;
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
      OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (in_src1 < in_src2)};
      OP_ADDW: begin
        w_word   = in_src1[31:0] + in_src2[31:0];
        w_result = sext32(w_word);
      end
      OP_SUBW: begin
        w_word   = in_src1[31:0] - in_src2[31:0];
        w_result = sext32(w_word);
      end
      default: w_result = '0;
    endcase
  end

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_wen    = r_out_wen;
  assign w_accept   = in_valid && in_ready;
  assign w_retire   = out_valid && out_ready;
`ifdef EXU_SKID_EN
  assign in_ready   = r_in_ready;
`else
  assign in_ready   = !out_valid || out_ready;
`endif

  // The output register is always the oldest entry; the skid entry only fills while it stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_out_result <= '0;
      r_out_rd     <= '0;
      r_out_wen    <= 1'b0;
`ifdef EXU_SKID_EN
      r_skid_result <= '0;
      r_skid_rd     <= '0;
      r_skid_wen    <= 1'b0;
      r_in_ready    <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out_result <= w_result;
            r_out_rd     <= in_rd;
            r_out_wen    <= in_wen;
            r_state      <= ST_ONE;
          end
        end
`ifdef EXU_SKID_EN
        ST_ONE: begin
          if (w_accept && !w_retire) begin
            r_skid_result <= w_result;
            r_skid_rd     <= in_rd;
            r_skid_wen    <= in_wen;
            r_in_ready    <= 1'b0;
            r_state       <= ST_FULL;
          end else if (w_accept) begin
            r_out_result <= w_result;
            r_out_rd     <= in_rd;
            r_out_wen    <= in_wen;
          end else if (w_retire) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_retire) begin
            r_out_result <= r_skid_result;
            r_out_rd     <= r_skid_rd;
            r_out_wen    <= r_skid_wen;
            r_in_ready   <= 1'b1;
            r_state      <= ST_ONE;
          end
        end
`else
        ST_ONE: begin
          if (w_accept) begin
            r_out_result <= w_result;
            r_out_rd     <= in_rd;
            r_out_wen    <= in_wen;
          end else if (w_retire) begin
            r_state <= ST_EMPTY;
          end
        end
`endif
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_stage.sv
// Scoreboard bench for exu_stage: expected results queued at acceptance, compared while presented.
module tb_exu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ret_log[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        rnd_bp   = 1'b0;

  exu_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] sx(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  // Reference model written independently of the RTL structure.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] x;
    logic [4:0]  s5;
    logic [5:0]  s6;
    logic [63:0] sb;
    x  = a[31:0];
    s5 = b[4:0];
    s6 = b[5:0];
    sb = 64'h8000_0000_0000_0000;
    case (op)
      4'd0:  return sx((x >> s5) | (x[31] ? ~(32'hFFFF_FFFF >> s5) : 32'h0));
      4'd1:  return sx(x >> s5);
      4'd2:  return sx(x << s5);
      4'd3:  return a >> s6;
      4'd4:  return a << s6;
      4'd5:  return (a >> s6) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> s6) : 64'h0);
      4'd6:  return a + b;
      4'd7:  return a - b;
      4'd8:  return a & b;
      4'd9:  return a | b;
      4'd10: return a ^ b;
      4'd11: return ((a ^ sb) < (b ^ sb)) ? 64'd1 : 64'd0;
      4'd12: return (a < b) ? 64'd1 : 64'd0;
      4'd13: return sx(x + b[31:0]);
      4'd14: return sx(x - b[31:0]);
      default: return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("sb_result", out_result, sb_q[0].res);
          chk("sb_rd", 64'(out_rd), 64'(sb_q[0].rd));
          chk("sb_wen", 64'(out_wen), 64'(sb_q[0].wen));
          if (out_ready) begin
            ret_log.push_back(out_result);
            void'(sb_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back('{res: model(in_op, in_src1, in_src2), rd: in_rd, wen: in_wen});
    end
  end

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic wen);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_rd    = rd;
    in_wen   = wen;
  endtask

  // Holds the op until the accepting edge; returns with in_valid low just after that edge.
  task automatic wait_accept(input int unsigned limit, output int unsigned waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    for (int unsigned c = 0; c < limit; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic wen, output int unsigned waits);
    drive(op, a, b, rd, wen);
    wait_accept(300, waits);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (sb_q.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic dir_vec(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
    int unsigned w;
    issue(op, a, b, 5'd7, 1'b1, w);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk(tag, out_result, exp);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    logic [63:0] bp_exp [3];
    bp_exp = '{64'd2, 64'd2, 64'd1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_src1   = '0;
    in_src2   = '0;
    in_rd     = '0;
    in_wen    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wen", 64'(out_wen), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    dir_vec("sraw", 4'd0, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
    dir_vec("srl", 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd8, 64'h00FF_FFFF_FFFF_FFFF);
    dir_vec("sllw", 4'd2, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000);
    dir_vec("srl63", 4'd3, 64'h8000_0000_0000_0000, 64'h7F, 64'd1);
    dir_vec("sra63", 4'd5, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    dir_vec("srlw0", 4'd1, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000);
    dir_vec("add_wrap", 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    dir_vec("sub_wrap", 4'd7, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    dir_vec("slt_neg", 4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    dir_vec("sltu_big", 4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    dir_vec("addw_ovf", 4'd13, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    dir_vec("subw", 4'd14, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    dir_vec("op15", 4'd15, 64'd5, 64'd5, 64'd0);
    drain();

    // Back-pressure: the blocked op waits while outputs hold, then all retire in order.
    ret_log.delete();
    out_ready = 1'b0;
    issue(4'd6, 64'd1, 64'd1, 5'd1, 1'b1, w);
`ifdef EXU_SKID_EN
    issue(4'd7, 64'd5, 64'd3, 5'd2, 1'b1, w);
    chk("bp_second_waits", 64'(w), 64'd0);
    drive(4'd12, 64'd1, 64'd2, 5'd3, 1'b1);
`else
    drive(4'd7, 64'd5, 64'd3, 5'd2, 1'b1);
`endif
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_result", out_result, 64'd2);
      chk("bp_hold_rd", 64'(out_rd), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept(10, w);
`ifndef EXU_SKID_EN
    issue(4'd12, 64'd1, 64'd2, 5'd3, 1'b1, w);
`endif
    drain();
    chk("bp_count", 64'(ret_log.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < ret_log.size()) ? ret_log[i] : 64'hDEAD, bp_exp[i]);

    // Simultaneous accept and retire from ONE sustains one op per cycle.
    issue(4'd6, 64'd10, 64'd20, 5'd4, 1'b1, w);
    for (int i = 0; i < 10; i++) begin
      chk("thru_out_valid", 64'(out_valid), 64'd1);
      chk("thru_in_ready", 64'(in_ready), 64'd1);
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 5'(i), 1'b1, w);
      chk("thru_waits", 64'(w), 64'd0);
    end
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 60; i++)
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), w);
    rnd_bp = 1'b0;
    drain();

    // Reset with the buffer stalled discards everything in flight.
    out_ready = 1'b0;
    issue(4'd6, 64'd3, 64'd4, 5'd9, 1'b1, w);
`ifdef EXU_SKID_EN
    issue(4'd6, 64'd5, 64'd6, 5'd10, 1'b1, w);
`endif
    @(negedge clk);
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_result", out_result, 64'd0);
    chk("async_rst_rd", 64'(out_rd), 64'd0);
    chk("async_rst_wen", 64'(out_wen), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_result", out_result, 64'd0);

    out_ready = 1'b1;
    @(posedge clk); #1;
    dir_vec("after_rst", 4'd8, 64'hF0F0, 64'hFF00, 64'hF000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
